// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add cell and a carry flip-flop produce
// A + B + cin one bit per clock, LSB first, with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_bit;
    logic             w_carryNext;

    assign w_bit       = r_aSh[0] ^ r_bSh[0] ^ r_carry;
    assign w_carryNext = (r_aSh[0] & r_bSh[0]) | ((r_aSh[0] ^ r_bSh[0]) & r_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new request exactly like IDLE, giving back-to-back operation
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_aSh   <= bus.a;
                        r_bSh   <= bus.b;
                        r_carry <= bus.cin;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res   <= {w_bit, r_res[WIDTH-1:1]};
                    r_aSh   <= r_aSh >> 1;
                    r_bSh   <= r_bSh >> 1;
                    r_carry <= w_carryNext;
                    r_count <= r_count + 1'b1;
                    // On the MSB step r_carry is the carry into the MSB
                    if (r_count == LAST) begin
                        r_sum   <= {w_bit, r_res[WIDTH-1:1]};
                        r_cout  <= w_carryNext;
                        r_ovf   <= r_carry ^ w_carryNext;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive self-checking bench for the 4-bit serial adder.
// Expected results are hand-computed or derived from integer arithmetic.
module tb_serial_adder;
    localparam int WIDTH = 4;
    localparam int TIMEOUT = 20;

    logic clk;
    logic rst;
    int   checksTotal;
    int   checksPassed;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one request for a single accepting edge, leaving the bench just after that edge
    task automatic applyStimulus(input int a, input int b, input int cin);
        bus.a     = WIDTH'(a);
        bus.b     = WIDTH'(b);
        bus.cin   = 1'(cin);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int ticks, output int busyCycles);
        ticks = 0;
        busyCycles = 0;
        while (!bus.done && ticks < TIMEOUT) begin
            if (bus.busy) busyCycles++;
            tick();
            ticks++;
        end
    endtask

    task automatic runOp(input int a, input int b, input int cin,
                         input int expSum, input int expCout, input int expOvf);
        int ticks;
        int busyCycles;
        applyStimulus(a, b, cin);
        waitDone(ticks, busyCycles);
        checkOutput("latency", ticks, WIDTH);
        checkOutput("busyCycles", busyCycles, WIDTH);
        checkOutput("doneHigh", bus.done, 1);
        checkOutput("sum", bus.sum, expSum);
        checkOutput("cout", bus.cout, expCout);
        checkOutput("ovf", bus.ovf, expOvf);
        tick();
        checkOutput("donePulse", bus.done, 0);
        checkOutput("busyAfter", bus.busy, 0);
        checkOutput("sumHeld", bus.sum, expSum);
    endtask

    initial begin
        int ticks;
        int busyCycles;
        int doneSeen;
        checksTotal  = 0;
        checksPassed = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.done, 0);
        checkOutput("rstSum", bus.sum, 0);
        checkOutput("rstCout", bus.cout, 0);
        checkOutput("rstOvf", bus.ovf, 0);

        runOp(3, 5, 0, 8, 0, 1);
        tick();
        checkOutput("idleSumHeld", bus.sum, 8);
        runOp(15, 1, 0, 0, 1, 0);
        runOp(7, 0, 1, 8, 0, 1);
        runOp(8, 8, 0, 0, 1, 1);

        // Start held high; operands change mid-run and must be ignored until DONE
        bus.a = 4'd2; bus.b = 4'd2; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        tick();
        bus.a = 4'd9; bus.b = 4'd9;
        waitDone(ticks, busyCycles);
        checkOutput("b2bFirstLatency", ticks + 1, WIDTH);
        checkOutput("b2bFirstSum", bus.sum, 4);
        checkOutput("b2bFirstCout", bus.cout, 0);
        checkOutput("b2bFirstOvf", bus.ovf, 0);
        tick();
        checkOutput("b2bNoGapBusy", bus.busy, 1);
        checkOutput("b2bSumHeldInRun", bus.sum, 4);
        waitDone(ticks, busyCycles);
        checkOutput("b2bSecondGap", ticks + 1, WIDTH + 1);
        checkOutput("b2bSecondSum", bus.sum, 2);
        checkOutput("b2bSecondCout", bus.cout, 1);
        checkOutput("b2bSecondOvf", bus.ovf, 1);
        bus.start = 1'b0;
        tick();
        checkOutput("b2bIdleBusy", bus.busy, 0);
        checkOutput("b2bIdleDone", bus.done, 0);

        // Reset in the second RUN cycle discards the partial result
        applyStimulus(6, 7, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRstBusy", bus.busy, 0);
        checkOutput("midRstDone", bus.done, 0);
        checkOutput("midRstSum", bus.sum, 0);
        checkOutput("midRstCout", bus.cout, 0);
        checkOutput("midRstOvf", bus.ovf, 0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) doneSeen++;
            tick();
        end
        checkOutput("midRstNoDone", doneSeen, 0);
        runOp(6, 7, 0, 13, 0, 1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int total;
                    int sa;
                    int sb;
                    int sTotal;
                    total  = a + b + c;
                    sa     = (a >= 8) ? a - 16 : a;
                    sb     = (b >= 8) ? b - 16 : b;
                    sTotal = sa + sb + c;
                    runOp(a, b, c, total % 16, total / 16,
                          (sTotal > 7 || sTotal < -8) ? 1 : 0);
                end
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder. Computes A + B + cin one bit per clock, LSB first, using a single full-add cell and a carry flip-flop.
- Forward (addition) counterpart to the team's subtractor datapath; used where area matters more than latency.
- Operands are captured on a start request. The result is returned with a one-cycle done pulse and held until the next operation.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  operation request; sampled at rising edge
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout/ovf valid
- sum  output  WIDTH  result bits
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, bit counter and carry flip-flop cleared. Reset has priority over everything, including mid-operation; a partial result is discarded.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE: start=1 -> capture a, b into shift registers and cin into the carry flip-flop; count=0; go to RUN. start=0 -> stay.
- RUN, each edge:
  - bit = a_sh[0]^b_sh[0]^c; c_next = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&c).
  - Shift bit into the result register from the MSB end; shift a_sh and b_sh right; count++.
  - On the MSB step (count==WIDTH-1): record carry-in-to-MSB = c, and go to DONE.
- Entering DONE: sum = full result register; cout = final carry; ovf = carry-in-to-MSB ^ final carry.
- Latency: start sampled at edge k -> done=1 during the cycle after edge k+WIDTH. Exactly WIDTH RUN cycles.
- DONE: lasts exactly one cycle.
  - start=1 -> capture new operands and go to RUN (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- start while busy: ignored; no effect on operands, count or result.
- a, b, cin are don't-care except at the accepting edge.
- sum/cout/ovf hold their last completed value from DONE through IDLE and the whole next RUN. They change only on entry to DONE or on reset; no partial bits are visible.
- Arithmetic: modulo 2^WIDTH; cout gives the unsigned carry; ovf is meaningful for two's-complement operands.

Test Plan (WIDTH=4):
- Reset, then a=3, b=5, cin=0, start 1 cycle -> busy high 4 cycles; done pulses 1 cycle; sum=8, cout=0, ovf=1; busy/done low afterwards, sum held at 8.
- a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0. Then a=7, b=0, cin=1 -> sum=8, cout=0, ovf=1. Then a=8, b=8, cin=0 -> sum=0, cout=1, ovf=1.
- start held high continuously with a=2, b=2 changing to a=9, b=9 mid-RUN -> first done gives sum=4; new capture occurs in the DONE cycle with the then-current a=9, b=9; second done 5 cycles later gives sum=2, cout=1, ovf=1.
- Assert rst on the 2nd RUN cycle of a=6, b=7 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows; a new start then completes normally.
- Exhaustive sweep of all a, b in 0..15 and cin in 0..1 -> {cout,sum} == a+b+cin and ovf matches the signed check; done pulses exactly once per start; latency is always 4 cycles.
